// File: rtl/adc_frontend_pkg.sv
// ============================================================================
// Module      : adc_frontend_pkg
// Description : Shared ADC front-end constants, serializer state encoding and
//               the word <-> DDR lane-pair mapping used by assembler/serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_frontend_pkg;

    localparam int ADC_LANES     = 8;
    localparam int ADC_DATA_BITS = 14;
    localparam int ADC_WORD_W    = 2 * ADC_LANES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TEST = 2'd2
    } ser_state_e;

    typedef struct packed {
        logic [ADC_LANES-1:0] rise;
        logic [ADC_LANES-1:0] fall;
    } lane_pair_t;

    // Even word bits ride the rising half-cycle, odd bits the falling one.
    function automatic lane_pair_t map_word(input logic [ADC_WORD_W-1:0] w,
                                            input int                    data_bits);
        lane_pair_t p;
        p = '0;
        for (int i = 0; i < ADC_LANES; i++) begin
            p.rise[i] = (2*i   < data_bits) ? w[2*i]   : 1'b0;
            p.fall[i] = (2*i+1 < data_bits) ? w[2*i+1] : 1'b0;
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ser_skid_fifo.sv
// ============================================================================
// Module      : ser_skid_fifo
// Description : 2-entry FIFO; ready depends only on the stored count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_skid_fifo #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             w_push;
    logic             w_pop;

    assign push_ready_o = (count_q != 2'd2);
    assign empty_o      = (count_q == 2'd0);
    assign w_push       = push_valid_i && push_ready_o;
    assign w_pop        = pop_i && !empty_o;
    assign pop_data_o   = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 2'd1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/word_serializer.sv
// ============================================================================
// Module      : word_serializer
// Description : Buffers parallel sample words and drives them onto DDR lanes
//               as rise/fall bit pairs; counts starved cycles.
//               ADC_SER_TESTPAT_EN adds a TEST state emitting a ramp pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_serializer
    import adc_frontend_pkg::*;
#(
    parameter int LANES      = ADC_LANES,
    parameter int DATA_BITS  = ADC_DATA_BITS,
    parameter int UNDERRUN_W = 16
) (
    input  logic                  dco_clk,
    input  logic                  rst_n,
    input  logic [2*LANES-1:0]    word_in,
    input  logic                  word_in_valid,
    output logic                  word_in_ready,
    input  logic                  test_mode,
    output logic [LANES-1:0]      rise_bits,
    output logic [LANES-1:0]      fall_bits,
    output logic                  lane_valid,
    output logic [UNDERRUN_W-1:0] underrun_count
);

    localparam int WORD_W = 2 * LANES;

    ser_state_e            state_q;
    logic [LANES-1:0]      rise_q;
    logic [LANES-1:0]      fall_q;
    logic                  valid_q;
    logic [UNDERRUN_W-1:0] underrun_q;

    logic                  w_fifo_ready;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_in_test;
    logic [DATA_BITS-1:0]  w_fifo_data;
    logic [DATA_BITS-1:0]  w_src;
    logic [LANES-1:0]      w_rise;
    logic [LANES-1:0]      w_fall;
    logic [WORD_W-1:0]     w_unused_word;

    // Bits at or above DATA_BITS are never transmitted, so they are not stored.
    assign w_unused_word = word_in;

`ifdef ADC_SER_TESTPAT_EN
    logic [DATA_BITS-1:0] ramp_q;

    assign w_in_test = (state_q == ST_TEST);
    assign w_pop     = !w_in_test && !test_mode;
    assign w_src     = w_in_test ? ramp_q : w_fifo_data;
`else
    logic w_unused_test_mode;

    assign w_unused_test_mode = test_mode;
    assign w_in_test          = 1'b0;
    assign w_pop              = 1'b1;
    assign w_src              = w_fifo_data;
`endif

    assign word_in_ready = w_fifo_ready && !w_in_test;

    ser_skid_fifo #(
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk          (dco_clk),
        .rst_n        (rst_n),
        .push_data_i  (word_in[DATA_BITS-1:0]),
        .push_valid_i (word_in_valid && !w_in_test),
        .push_ready_o (w_fifo_ready),
        .pop_i        (w_pop),
        .pop_data_o   (w_fifo_data),
        .empty_o      (w_empty)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (2*i < DATA_BITS) begin : g_rise
            assign w_rise[i] = w_src[2*i];
        end else begin : g_rise_zero
            assign w_rise[i] = 1'b0;
        end
        if (2*i+1 < DATA_BITS) begin : g_fall
            assign w_fall[i] = w_src[2*i+1];
        end else begin : g_fall_zero
            assign w_fall[i] = 1'b0;
        end
    end

    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rise_q     <= '0;
            fall_q     <= '0;
            valid_q    <= 1'b0;
            underrun_q <= '0;
`ifdef ADC_SER_TESTPAT_EN
            ramp_q     <= '0;
`endif
        end
`ifdef ADC_SER_TESTPAT_EN
        else if (state_q == ST_TEST) begin
            if (!test_mode) begin
                state_q <= ST_IDLE;
                rise_q  <= '0;
                fall_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                rise_q  <= w_rise;
                fall_q  <= w_fall;
                valid_q <= 1'b1;
                ramp_q  <= ramp_q + 1'b1;
            end
        end else if (test_mode) begin
            // Entry cycle already emits ramp value 0, which maps to all-zero lanes.
            state_q <= ST_TEST;
            rise_q  <= '0;
            fall_q  <= '0;
            valid_q <= 1'b1;
            ramp_q  <= DATA_BITS'(1);
        end
`endif
        else if (!w_empty) begin
            state_q <= ST_RUN;
            rise_q  <= w_rise;
            fall_q  <= w_fall;
            valid_q <= 1'b1;
        end else begin
            rise_q  <= '0;
            fall_q  <= '0;
            valid_q <= 1'b0;
            if ((state_q == ST_RUN) && (underrun_q != {UNDERRUN_W{1'b1}})) begin
                underrun_q <= underrun_q + 1'b1;
            end
        end
    end

    assign rise_bits      = rise_q;
    assign fall_bits      = fall_q;
    assign lane_valid     = valid_q;
    assign underrun_count = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_word_serializer.sv
// ============================================================================
// Module      : tb_word_serializer
// Description : Self-checking bench for word_serializer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_word_serializer;

    localparam int LANES      = 8;
    localparam int DATA_BITS  = 14;
    localparam int UNDERRUN_W = 16;

    logic        dco_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] word_in = '0;
    logic        word_in_valid = 1'b0;
    logic        test_mode = 1'b0;
    logic        word_in_ready;
    logic [7:0]  rise_bits;
    logic [7:0]  fall_bits;
    logic        lane_valid;
    logic [15:0] underrun_count;

    word_serializer #(
        .LANES      (LANES),
        .DATA_BITS  (DATA_BITS),
        .UNDERRUN_W (UNDERRUN_W)
    ) dut (
        .dco_clk        (dco_clk),
        .rst_n          (rst_n),
        .word_in        (word_in),
        .word_in_valid  (word_in_valid),
        .word_in_ready  (word_in_ready),
        .test_mode      (test_mode),
        .rise_bits      (rise_bits),
        .fall_bits      (fall_bits),
        .lane_valid     (lane_valid),
        .underrun_count (underrun_count)
    );

    always #5 dco_clk = ~dco_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of pending words plus a few behavioural flags.
    logic [15:0]          m_q[$];
    bit                   m_started;
    bit                   m_intest;
    int                   m_under;
    logic [DATA_BITS-1:0] m_ramp;
    logic [32:0]          e_pack;
    logic                 e_ready;
    logic                 o_ready;
    logic [32:0]          obs;

    assign obs = {rise_bits, fall_bits, lane_valid, underrun_count};

    function automatic logic [15:0] split(input logic [15:0] w);
        logic [15:0] m;
        logic [7:0]  r;
        logic [7:0]  f;
        m = w & 16'((32'd1 << DATA_BITS) - 1);
        r = '0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = m[2*i];
            f[i] = m[2*i+1];
        end
        return {r, f};
    endfunction

    function automatic logic [32:0] pack(input logic [15:0] rf, input logic v, input int u);
        return {rf, v, 16'(u)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_started = 0;
        m_intest  = 0;
        m_under   = 0;
        m_ramp    = '0;
        e_pack    = '0;
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic tm);
        bit push;
        bit done;
        @(negedge dco_clk);
        word_in_valid = v;
        word_in       = d;
        test_mode     = tm;
        e_ready = (m_q.size() < 2) && !m_intest;
        o_ready = word_in_ready;
        push    = v && e_ready;
        @(posedge dco_clk);
        done = 0;
`ifdef ADC_SER_TESTPAT_EN
        if (m_intest) begin
            if (tm) begin
                e_pack = pack(split(16'(m_ramp)), 1'b1, m_under);
                m_ramp = m_ramp + 1'b1;
            end else begin
                m_intest  = 0;
                m_started = 0;
                e_pack    = pack(16'h0, 1'b0, m_under);
            end
            done = 1;
        end else if (tm) begin
            m_intest = 1;
            e_pack   = pack(split(16'h0), 1'b1, m_under);
            m_ramp   = 1;
            done     = 1;
        end
`endif
        if (!done) begin
            if (m_q.size() > 0) begin
                e_pack    = pack(split(m_q.pop_front()), 1'b1, m_under);
                m_started = 1;
            end else begin
                if (m_started && m_under < 65535) m_under++;
                e_pack = pack(16'h0, 1'b0, m_under);
            end
        end
        if (push) m_q.push_back(d);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge dco_clk);
        rst_n = 1'b0;
        word_in_valid = 1'b0;
        test_mode = 1'b0;
        model_reset();
        @(negedge dco_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge dco_clk);
        checks++;
        if (word_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", word_in_ready);
        end
        checks++;
        if (obs !== 33'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", obs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        step(1'b1, 16'h2A5C, 1'b0);
        checks++;
        if (obs !== e_pack) begin
            failures++;
            $display("FAIL single_accept_cycle got=%h want=%h", obs, e_pack);
        end
        step(1'b0, 16'h0, 1'b0);
        checks++;
        if (obs !== e_pack || lane_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_word got=%h want=%h", obs, e_pack);
        end
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        checks++;
        if (obs !== e_pack || {rise_bits[7], fall_bits[7]} !== 2'b00) begin
            failures++;
            $display("FAIL upper_bits_zero got=%h want=%h", obs, e_pack);
        end
    endtask

    task automatic test_back_to_back();
        int nvalid;
        int nready_bad;
        int nbad;
        pulse_reset();
        nvalid = 0;
        nready_bad = 0;
        nbad = 0;
        for (int k = 0; k < 12; k++) begin
            step(k < 10, 16'($urandom), 1'b0);
            if (o_ready !== 1'b1) nready_bad++;
            if (obs !== e_pack) nbad++;
            if (lane_valid === 1'b1) nvalid++;
        end
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL b2b_stream got=%0d bad cycles want=0", nbad);
        end
        checks++;
        if (nvalid != 10 || nready_bad != 0) begin
            failures++;
            $display("FAIL b2b_count got valid=%0d ready_drops=%0d want 10/0", nvalid, nready_bad);
        end
    endtask

    task automatic test_stall();
        pulse_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b0);
        checks++;
        if (underrun_count !== 16'd0 || obs !== e_pack) begin
            failures++;
            $display("FAIL idle_no_underrun got=%0d want=0", underrun_count);
        end
        step(1'b1, 16'($urandom), 1'b0);
        step(1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'h0, 1'b0);
            checks++;
            if (obs !== e_pack || lane_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_gap[%0d] got=%h want=%h", k, obs, e_pack);
            end
        end
        checks++;
        if (underrun_count !== 16'd3) begin
            failures++;
            $display("FAIL stall_count got=%0d want=3", underrun_count);
        end
    endtask

    task automatic test_reset_mid();
        int nbad;
        pulse_reset();
        step(1'b1, 16'h1234, 1'b0);
        step(1'b1, 16'h0ABC, 1'b0);
        rst_n = 1'b0;
        word_in_valid = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 33'h0 || word_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got=%h ready=%b want=0 ready=1", obs, word_in_ready);
        end
        @(negedge dco_clk);
        rst_n = 1'b1;
        nbad = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 16'h0, 1'b0);
            if (obs !== e_pack || lane_valid !== 1'b0) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL reset_no_stale got=%0d bad cycles want=0", nbad);
        end
    endtask

    task automatic test_random();
        int nbad;
        pulse_reset();
        nbad = 0;
        for (int k = 0; k < 200; k++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom), 1'b0);
            if (obs !== e_pack || o_ready !== e_ready) begin
                nbad++;
                if (nbad <= 5)
                    $display("FAIL random[%0d] got=%h ready=%b want=%h ready=%b",
                             k, obs, o_ready, e_pack, e_ready);
            end
        end
        checks++;
        if (nbad != 0) failures++;
    endtask

`ifdef ADC_SER_TESTPAT_EN
    task automatic test_testpat();
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 16'h0, 1'b1);
            checks++;
            if (obs !== e_pack || lane_valid !== 1'b1) begin
                failures++;
                $display("FAIL ramp[%0d] got=%h want=%h", k, obs, e_pack);
            end
        end
        step(1'b0, 16'h0, 1'b0);
        checks++;
        if (obs !== e_pack) begin
            failures++;
            $display("FAIL ramp_exit got=%h want=%h", obs, e_pack);
        end
        step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h2222, 1'b1);
        step(1'b1, 16'h3333, 1'b1);
        checks++;
        if (o_ready !== 1'b0 || e_ready !== 1'b0) begin
            failures++;
            $display("FAIL test_hold_ready got=%b want=0", o_ready);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 16'h0, 1'b0);
            checks++;
            if (obs !== e_pack) begin
                failures++;
                $display("FAIL test_resume[%0d] got=%h want=%h", k, obs, e_pack);
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef ADC_SER_TESTPAT_EN
        test_testpat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
